// File: rtl/wb_arb_pkg.sv
// Purpose: shared types for the wishbone memory arbiter.
//   arb_state_t : arbiter FSM state (idle or which master owns the memory port)
//   mst_t       : master identifier used by the round-robin pointer
//   rr_pick_i   : tie-break helper, true when the ifetch master should win
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    MST_I = 1'b0,
    MST_D = 1'b1
  } mst_t;

  // I wins when it is the only requester, or both request and D was served last.
  function automatic logic rr_pick_i(input logic i_req, input logic d_req,
                                     input mst_t last);
    return i_req && (!d_req || (last == MST_D));
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Purpose: no-ACK watchdog for the wishbone memory arbiter. Counts cycles a
// granted transfer spends waiting for termination and flags the cycle in
// which the TMO-th wait cycle is reached.
// Ports:
//   Clk    in  clock
//   Reset  in  synchronous active-high reset
//   clr    in  restart the count (asserted whenever no transfer is pending
//              or the current owner is leaving)
//   en     in  count this cycle (owner waiting, no termination seen)
//   expire out high during the TMO-th waiting cycle; never high when TMO=0
module wb_arb_watchdog #(
  parameter int TMO = 256
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'((TMO > 0) ? (TMO - 1) : 0);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge Clk) begin
    if (Reset || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // The count never passes LAST_CNT: expiry forces the owner out, which clears it.
  assign expire = (TMO > 0) && en && (r_cnt == LAST_CNT);

endmodule

// File: rtl/wb_mem_arbiter.sv
// Purpose: shares one wishbone memory port between the instruction-fetch
// master (i_*) and the data master (d_*). Single-beat transfers, round-robin
// fairness between the two masters, and a watchdog that answers RTY when the
// slave never terminates a granted transfer.
// Ports:
//   Clk, Reset                      clock, synchronous active-high reset
//   i_CYC/i_STB/i_WE/i_SEL/i_ADR/i_DAT_M  ifetch master request
//   i_DAT_S/i_ACK/i_RTY             ifetch master response
//   d_*                             same set for the data master
//   m_CYC/m_STB/m_WE/m_SEL/m_ADR/m_DAT_M  request towards the memory slave
//   m_DAT_S/m_ACK/m_RTY             response from the memory slave
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADR_W  = 28,
  parameter int DATA_W = 128,
  parameter int TMO    = 256,
  localparam int SEL_W = DATA_W / 8
) (
  input  logic              Clk,
  input  logic              Reset,
  // ifetch master
  input  logic              i_CYC,
  input  logic              i_STB,
  input  logic              i_WE,
  input  logic [SEL_W-1:0]  i_SEL,
  input  logic [ADR_W-1:0]  i_ADR,
  input  logic [DATA_W-1:0] i_DAT_M,
  output logic [DATA_W-1:0] i_DAT_S,
  output logic              i_ACK,
  output logic              i_RTY,
  // data master
  input  logic              d_CYC,
  input  logic              d_STB,
  input  logic              d_WE,
  input  logic [SEL_W-1:0]  d_SEL,
  input  logic [ADR_W-1:0]  d_ADR,
  input  logic [DATA_W-1:0] d_DAT_M,
  output logic [DATA_W-1:0] d_DAT_S,
  output logic              d_ACK,
  output logic              d_RTY,
  // memory slave
  output logic              m_CYC,
  output logic              m_STB,
  output logic              m_WE,
  output logic [SEL_W-1:0]  m_SEL,
  output logic [ADR_W-1:0]  m_ADR,
  output logic [DATA_W-1:0] m_DAT_M,
  input  logic [DATA_W-1:0] m_DAT_S,
  input  logic              m_ACK,
  input  logic              m_RTY
);

  arb_state_t r_state, w_state_nxt;
  mst_t       r_last,  w_last_nxt;

  logic w_i_req, w_d_req;
  logic w_own_i, w_own_d;
  logic w_term, w_expire, w_done;
  logic w_wd_clr, w_wd_en;

  assign w_i_req = i_CYC & i_STB;
  assign w_d_req = d_CYC & d_STB;

  // Reset also blanks the muxes so a pending slave ACK is never forwarded
  // in the cycle reset is applied.
  assign w_own_i = (r_state == OWN_I) & ~Reset;
  assign w_own_d = (r_state == OWN_D) & ~Reset;

  assign w_term = m_ACK | m_RTY;
  assign w_done = w_term | w_expire;

  // Watchdog restarts while idle and whenever the owner leaves (termination,
  // timeout or abort), so every fresh grant starts from zero.
  assign w_wd_en  = (r_state != IDLE) & ~w_term;
  assign w_wd_clr = (r_state == IDLE) | w_done |
                    ((r_state == OWN_I) & ~i_CYC) |
                    ((r_state == OWN_D) & ~d_CYC);

  wb_arb_watchdog #(
    .TMO (TMO)
  ) u_wdog (
    .Clk    (Clk),
    .Reset  (Reset),
    .clr    (w_wd_clr),
    .en     (w_wd_en),
    .expire (w_expire)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_last  <= MST_D;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next state. A terminating owner hands straight to the other master if it
  // is waiting; the finishing master's own request is ignored that cycle so
  // it cannot take two grants in a row while the other waits.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    unique case (r_state)
      IDLE: begin
        if (rr_pick_i(w_i_req, w_d_req, r_last)) begin
          w_state_nxt = OWN_I;
        end else if (w_d_req) begin
          w_state_nxt = OWN_D;
        end
      end
      OWN_I: begin
        if (w_done) begin
          w_last_nxt  = MST_I;
          w_state_nxt = w_d_req ? OWN_D : IDLE;
        end else if (!i_CYC) begin
          w_state_nxt = IDLE;
        end
      end
      OWN_D: begin
        if (w_done) begin
          w_last_nxt  = MST_D;
          w_state_nxt = w_i_req ? OWN_I : IDLE;
        end else if (!d_CYC) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output muxes. On timeout the slave cycle is dropped and the owner sees RTY.
  always_comb begin
    m_CYC   = 1'b0;
    m_STB   = 1'b0;
    m_WE    = 1'b0;
    m_SEL   = '0;
    m_ADR   = '0;
    m_DAT_M = '0;
    i_ACK   = 1'b0;
    i_RTY   = 1'b0;
    i_DAT_S = '0;
    d_ACK   = 1'b0;
    d_RTY   = 1'b0;
    d_DAT_S = '0;
    if (w_own_i) begin
      m_CYC   = i_CYC & ~w_expire;
      m_STB   = i_STB & ~w_expire;
      m_WE    = i_WE;
      m_SEL   = i_SEL;
      m_ADR   = i_ADR;
      m_DAT_M = i_DAT_M;
      i_ACK   = m_ACK;
      i_RTY   = m_RTY | w_expire;
      i_DAT_S = m_DAT_S;
    end else if (w_own_d) begin
      m_CYC   = d_CYC & ~w_expire;
      m_STB   = d_STB & ~w_expire;
      m_WE    = d_WE;
      m_SEL   = d_SEL;
      m_ADR   = d_ADR;
      m_DAT_M = d_DAT_M;
      d_ACK   = m_ACK;
      d_RTY   = m_RTY | w_expire;
      d_DAT_S = m_DAT_S;
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: ifetch/data arbitration, write muxing,
// watchdog RTY, reset mid-transfer and master abort.
module tb_wb_mem_arbiter;

  localparam int ADR_W  = 28;
  localparam int DATA_W = 128;
  localparam int SEL_W  = DATA_W / 8;
  localparam int TMO    = 8;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              i_CYC, i_STB, i_WE;
  logic [SEL_W-1:0]  i_SEL;
  logic [ADR_W-1:0]  i_ADR;
  logic [DATA_W-1:0] i_DAT_M, i_DAT_S;
  logic              i_ACK, i_RTY;
  logic              d_CYC, d_STB, d_WE;
  logic [SEL_W-1:0]  d_SEL;
  logic [ADR_W-1:0]  d_ADR;
  logic [DATA_W-1:0] d_DAT_M, d_DAT_S;
  logic              d_ACK, d_RTY;
  logic              m_CYC, m_STB, m_WE;
  logic [SEL_W-1:0]  m_SEL;
  logic [ADR_W-1:0]  m_ADR;
  logic [DATA_W-1:0] m_DAT_M, m_DAT_S;
  logic              m_ACK, m_RTY;

  int n_chk = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  wb_mem_arbiter #(
    .ADR_W (ADR_W),
    .DATA_W(DATA_W),
    .TMO   (TMO)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .i_CYC(i_CYC), .i_STB(i_STB), .i_WE(i_WE), .i_SEL(i_SEL), .i_ADR(i_ADR),
    .i_DAT_M(i_DAT_M), .i_DAT_S(i_DAT_S), .i_ACK(i_ACK), .i_RTY(i_RTY),
    .d_CYC(d_CYC), .d_STB(d_STB), .d_WE(d_WE), .d_SEL(d_SEL), .d_ADR(d_ADR),
    .d_DAT_M(d_DAT_M), .d_DAT_S(d_DAT_S), .d_ACK(d_ACK), .d_RTY(d_RTY),
    .m_CYC(m_CYC), .m_STB(m_STB), .m_WE(m_WE), .m_SEL(m_SEL), .m_ADR(m_ADR),
    .m_DAT_M(m_DAT_M), .m_DAT_S(m_DAT_S), .m_ACK(m_ACK), .m_RTY(m_RTY)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  // Inputs are changed 1 ns after the rising edge and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_all();
    i_CYC = 0; i_STB = 0; i_WE = 0; i_SEL = '0; i_ADR = '0; i_DAT_M = '0;
    d_CYC = 0; d_STB = 0; d_WE = 0; d_SEL = '0; d_ADR = '0; d_DAT_M = '0;
    m_ACK = 0; m_RTY = 0; m_DAT_S = '0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    idle_all();
    tick();
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    // ---- reset state
    do_reset();
    settle();
    chk("rst_m_cyc",  m_CYC, 0);
    chk("rst_m_adr",  m_ADR, 0);
    chk("rst_i_ack",  i_ACK, 0);
    chk("rst_d_rty",  d_RTY, 0);
    chk("rst_i_dats", i_DAT_S, 0);

    // ---- 1: single ifetch read, ACK on third owned cycle
    i_CYC = 1; i_STB = 1; i_SEL = 16'hFFFF; i_ADR = 28'h0000100;
    settle();
    chk("t1_no_comb_grant", m_CYC, 0);
    tick();
    settle();
    chk("t1_m_cyc", m_CYC, 1);
    chk("t1_m_adr", m_ADR, 28'h0000100);
    tick();
    settle();
    chk("t1_wait_ack", i_ACK, 0);
    tick();
    m_ACK = 1; m_DAT_S = 128'h0123456789ABCDEF_FEDCBA9876543210;
    settle();
    chk("t1_i_ack",   i_ACK, 1);
    chk("t1_i_dats",  i_DAT_S, 128'h0123456789ABCDEF_FEDCBA9876543210);
    chk("t1_d_ack",   d_ACK, 0);
    chk("t1_d_dats",  d_DAT_S, 0);
    tick();
    i_CYC = 0; i_STB = 0; m_ACK = 0; m_DAT_S = '0;
    settle();
    chk("t1_ack_gone", i_ACK, 0);
    chk("t1_idle_cyc", m_CYC, 0);

    // ---- 2: simultaneous requests after reset alternate I,D,I,D
    do_reset();
    i_CYC = 1; i_STB = 1; i_ADR = 28'h111;
    d_CYC = 1; d_STB = 1; d_ADR = 28'h222;
    settle();
    chk("t2_idle_cyc", m_CYC, 0);
    tick();
    settle();
    chk("t2_g1_i", m_ADR, 28'h111);
    m_ACK = 1;
    settle();
    chk("t2_ack1_i", i_ACK, 1);
    chk("t2_ack1_d", d_ACK, 0);
    tick();
    i_CYC = 0; i_STB = 0; m_ACK = 0;
    settle();
    chk("t2_g2_d",   m_ADR, 28'h222);
    chk("t2_g2_cyc", m_CYC, 1);
    i_CYC = 1; i_STB = 1; m_ACK = 1;
    settle();
    chk("t2_ack2_d", d_ACK, 1);
    chk("t2_ack2_i", i_ACK, 0);
    tick();
    m_ACK = 0;
    settle();
    chk("t2_g3_i", m_ADR, 28'h111);
    m_ACK = 1;
    tick();
    i_CYC = 0; i_STB = 0; m_ACK = 0;
    settle();
    chk("t2_g4_d", m_ADR, 28'h222);
    m_ACK = 1;
    settle();
    chk("t2_ack4_d", d_ACK, 1);
    tick();
    d_CYC = 0; d_STB = 0; m_ACK = 0;
    settle();
    chk("t2_idle_end", m_CYC, 0);

    // ---- 3: data write muxing; ifetch waits until D terminates
    d_CYC = 1; d_STB = 1; d_WE = 1; d_SEL = 16'h00F0; d_ADR = 28'h0ABCDEF;
    d_DAT_M = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    tick();
    i_CYC = 1; i_STB = 1; i_WE = 0; i_ADR = 28'h333;
    settle();
    chk("t3_m_we",   m_WE, 1);
    chk("t3_m_sel",  m_SEL, 16'h00F0);
    chk("t3_m_dat",  m_DAT_M, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0);
    chk("t3_m_adr",  m_ADR, 28'h0ABCDEF);
    chk("t3_i_wait", i_ACK, 0);
    tick();
    settle();
    chk("t3_i_wait2", i_ACK, 0);
    chk("t3_m_adr2",  m_ADR, 28'h0ABCDEF);
    m_ACK = 1;
    settle();
    chk("t3_d_ack", d_ACK, 1);
    chk("t3_i_ack", i_ACK, 0);
    tick();
    d_CYC = 0; d_STB = 0; d_WE = 0; d_SEL = '0; d_DAT_M = '0; m_ACK = 0;
    settle();
    chk("t3_then_i", m_ADR, 28'h333);
    chk("t3_i_we",   m_WE, 0);
    m_ACK = 1; m_DAT_S = 128'h55;
    settle();
    chk("t3_i_dats", i_DAT_S, 128'h55);
    tick();
    i_CYC = 0; i_STB = 0; m_ACK = 0; m_DAT_S = '0;
    settle();
    chk("t3_idle", m_CYC, 0);

    // ---- 4: watchdog RTY on 8th owned cycle, then hand over to D
    i_CYC = 1; i_STB = 1; i_ADR = 28'h444;
    tick();
    for (int k = 1; k <= 7; k++) begin
      settle();
      chk("t4_no_rty", i_RTY, 0);
      chk("t4_cyc_on", m_CYC, 1);
      if (k == 4) begin
        d_CYC = 1; d_STB = 1; d_ADR = 28'h555;
      end
      tick();
    end
    settle();
    chk("t4_i_rty",   i_RTY, 1);
    chk("t4_cyc_off", m_CYC, 0);
    chk("t4_d_rty",   d_RTY, 0);
    tick();
    i_CYC = 0; i_STB = 0;
    settle();
    chk("t4_next_d",   m_ADR, 28'h555);
    chk("t4_d_cyc",    m_CYC, 1);
    chk("t4_rty_gone", i_RTY, 0);
    m_ACK = 1;
    settle();
    chk("t4_d_ack", d_ACK, 1);
    tick();
    d_CYC = 0; d_STB = 0; m_ACK = 0;

    // ---- 5: reset while D owns with ACK pending
    d_CYC = 1; d_STB = 1; d_ADR = 28'h666;
    tick();
    settle();
    chk("t5_own_d", m_CYC, 1);
    Reset = 1; m_ACK = 1;
    tick();
    Reset = 0; d_CYC = 0; d_STB = 0;
    settle();
    chk("t5_cyc_off", m_CYC, 0);
    chk("t5_no_dack", d_ACK, 0);
    tick();
    settle();
    chk("t5_late_dack", d_ACK, 0);
    chk("t5_late_iack", i_ACK, 0);
    m_ACK = 0;

    // ---- 6: abort keeps round-robin order; dual ACK+RTY is one termination
    i_CYC = 1; i_STB = 1; i_ADR = 28'h777;
    d_CYC = 1; d_STB = 1; d_ADR = 28'h888;
    tick();
    settle();
    chk("t6_own_i", m_ADR, 28'h777);
    i_CYC = 0; i_STB = 0;
    settle();
    chk("t6_abort_cyc", m_CYC, 0);
    chk("t6_abort_ack", i_ACK, 0);
    tick();
    settle();
    chk("t6_idle_cyc",  m_CYC, 0);
    chk("t6_idle_dack", d_ACK, 0);
    i_CYC = 1; i_STB = 1;
    tick();
    settle();
    chk("t6_regrant_i", m_ADR, 28'h777);
    m_ACK = 1;
    tick();
    i_CYC = 0; i_STB = 0; m_ACK = 0;
    settle();
    chk("t6_then_d", m_ADR, 28'h888);
    m_ACK = 1; m_RTY = 1;
    settle();
    chk("t6_d_ack", d_ACK, 1);
    chk("t6_d_rty", d_RTY, 1);
    tick();
    d_CYC = 0; d_STB = 0; m_ACK = 0; m_RTY = 0;
    settle();
    chk("t6_end_idle", m_CYC, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
